// File: rtl/dds_ctrl_pkg.sv
// Shared types and step-size helpers for the DDS frequency-control sequencer.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_LOAD
  } fsm_state_t;

  localparam logic [1:0] STEP_SEL_0 = 2'd0;
  localparam logic [1:0] STEP_SEL_1 = 2'd1;
  localparam logic [1:0] STEP_SEL_2 = 2'd2;

  localparam int unsigned STEP0 = 1;
  localparam int unsigned STEP1 = 10;
  localparam int unsigned STEP2 = 100;

  function automatic int unsigned step_size(input logic [1:0] sel);
    case (sel)
      STEP_SEL_1: return STEP1;
      STEP_SEL_2: return STEP2;
      default:    return STEP0;
    endcase
  endfunction

  function automatic logic [1:0] next_step_sel(input logic [1:0] sel);
    return (sel == STEP_SEL_2) ? STEP_SEL_0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low key: emits a single press pulse per qualified press,
// then waits for an equally qualified release before it can fire again.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             armed;
  logic             level_ok;
  logic [CNT_W-1:0] cnt;

  // While armed we qualify a low level; once fired we qualify a high level to re-arm.
  assign level_ok = armed ? ~sync_b : sync_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what makes sync_a -> sync_b a real two-stage chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      armed  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= key;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (!level_ok) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        armed <= ~armed;
        press <= armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_freq_ctrl.sv
// Key-driven frequency-code sequencer: saturating code update, FTW multiply and
// a valid/ready load of the tuning word into the DDS phase accumulator.
module dds_freq_ctrl #(
  parameter int unsigned CODE_W       = 9,
  parameter int unsigned CODE_MAX     = 400,
  parameter int unsigned RESET_CODE   = 10,
  parameter int unsigned FTW_W        = 32,
  parameter int unsigned FTW_PER_CODE = 85899,
  parameter int unsigned DEB_CYCLES   = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_up,
  input  logic              key_dn,
  input  logic              key_step,
  input  logic              ftw_ready,
  output logic [FTW_W-1:0]  ftw,
  output logic              ftw_valid,
  output logic [CODE_W-1:0] freq_code,
  output logic [1:0]        step_sel,
  output logic              busy
);

  import dds_ctrl_pkg::*;

  if (longint'(CODE_MAX) * longint'(FTW_PER_CODE) >= (longint'(1) << FTW_W)) begin : g_chk_ftw
    $fatal(1, "CODE_MAX * FTW_PER_CODE does not fit in FTW_W bits");
  end
  if (CODE_MAX >= (1 << CODE_W)) begin : g_chk_code_w
    $fatal(1, "CODE_MAX does not fit in CODE_W bits");
  end
  if (RESET_CODE > CODE_MAX || STEP0 > CODE_MAX || STEP1 > CODE_MAX || STEP2 > CODE_MAX)
  begin : g_chk_range
    $fatal(1, "RESET_CODE and every step size must not exceed CODE_MAX");
  end

  localparam int unsigned       SUM_W       = CODE_W + 1;
  localparam logic [SUM_W-1:0]  CODE_MAX_S  = SUM_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] CODE_MAX_C  = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] RESET_C     = CODE_W'(RESET_CODE);
  localparam logic [FTW_W-1:0]  FTW_K       = FTW_W'(FTW_PER_CODE);

  fsm_state_t        state;
  logic              press_up;
  logic              press_dn;
  logic              press_step;
  logic [SUM_W-1:0]  step_amt;
  logic [SUM_W-1:0]  code_ext;
  logic [SUM_W-1:0]  code_sum;
  logic [CODE_W-1:0] code_next;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk, .rst, .key(key_up), .press(press_up)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk, .rst, .key(key_dn), .press(press_dn)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk, .rst, .key(key_step), .press(press_step)
  );

  assign step_amt = SUM_W'(step_size(step_sel));
  assign code_ext = {1'b0, freq_code};
  assign code_sum = code_ext + step_amt;

  // NOTE: code_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    code_next = freq_code;
    if (press_up) begin
      code_next = (code_sum > CODE_MAX_S) ? CODE_MAX_C : code_sum[CODE_W-1:0];
    end else if (press_dn) begin
      code_next = (code_ext < step_amt) ? '0 : freq_code - step_amt[CODE_W-1:0];
    end
  end

  assign busy = (state != ST_IDLE);

  // Presses are only acted on in IDLE; step wins over up, up wins over dn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      freq_code <= RESET_C;
      step_sel  <= STEP_SEL_0;
      ftw       <= '0;
      ftw_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: state <= ST_CALC;
        ST_IDLE: begin
          if (press_step) begin
            step_sel <= next_step_sel(step_sel);
          end else if ((press_up || press_dn) && code_next != freq_code) begin
            freq_code <= code_next;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          ftw       <= FTW_W'(freq_code) * FTW_K;
          ftw_valid <= 1'b1;
          state     <= ST_LOAD;
        end
        ST_LOAD: begin
          if (ftw_ready) begin
            ftw_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Self-checking bench for dds_freq_ctrl: directed scenarios plus randomized key and
// ready traffic, compared every cycle against a behavioural model of the sequencer.
module tb_dds_freq_ctrl;

  localparam int D = 4;
  localparam longint K = 85899;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_up, key_dn, key_step, ftw_ready;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic [8:0]  freq_code;
  logic [1:0]  step_sel;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  dds_freq_ctrl #(.DEB_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn), .key_step(key_step),
    .ftw_ready(ftw_ready), .ftw(ftw), .ftw_valid(ftw_valid), .freq_code(freq_code),
    .step_sel(step_sel), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Each key keeps its last D+2 raw samples; the oldest D
  // (the two newest are still in the synchronizer) decide press and re-arm.
  logic [D+1:0] m_sh [3];
  bit     m_armed [3];
  bit     m_pulse [3];
  int     m_code, m_sel, m_calc_wait, m_step, m_new;
  longint m_ftw;
  bit     m_valid, m_busy;

  function automatic logic key_level(input int i);
    return (i == 0) ? key_up : (i == 1) ? key_dn : key_step;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_sh[i] = '1; m_armed[i] = 1'b1; m_pulse[i] = 1'b0;
      end
      m_code = 10; m_sel = 0; m_ftw = 0; m_valid = 0; m_busy = 1; m_calc_wait = 2;
    end else begin
      if (m_valid) begin
        if (ftw_ready) begin m_valid = 0; m_busy = 0; end
      end else if (m_calc_wait > 0) begin
        m_calc_wait--;
        if (m_calc_wait == 0) begin
          m_ftw = (longint'(m_code) * K) & 64'hFFFF_FFFF;
          m_valid = 1;
        end
      end else if (m_pulse[2]) begin
        m_sel = (m_sel + 1) % 3;
      end else if (m_pulse[0] || m_pulse[1]) begin
        m_step = (m_sel == 0) ? 1 : (m_sel == 1) ? 10 : 100;
        if (m_pulse[0]) m_new = (m_code + m_step > 400) ? 400 : m_code + m_step;
        else            m_new = (m_code < m_step) ? 0 : m_code - m_step;
        if (m_new != m_code) begin m_code = m_new; m_calc_wait = 1; m_busy = 1; end
      end
      for (int i = 0; i < 3; i++) begin
        m_sh[i] = {m_sh[i][D:0], key_level(i)};
        m_pulse[i] = 1'b0;
        if (m_armed[i] && m_sh[i][D+1:2] == '0) begin
          m_pulse[i] = 1'b1; m_armed[i] = 1'b0;
        end else if (!m_armed[i] && &m_sh[i][D+1:2]) begin
          m_armed[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model ftw_valid", ftw_valid, m_valid);
      check("model busy", busy, m_busy);
      check("model freq_code", freq_code, m_code);
      check("model step_sel", step_sel, m_sel);
      check("model ftw", ftw, m_ftw);
    end
    if (rst && ftw_valid && ftw_ready) n_loads++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up, input bit dn, input bit st);
    key_up = ~up; key_dn = ~dn; key_step = ~st;
    tick(6);
    key_up = 1'b1; key_dn = 1'b1; key_step = 1'b1;
    tick(12);
  endtask

  int l0;

  initial begin
    rst = 1'b1; key_up = 1'b1; key_dn = 1'b1; key_step = 1'b1; ftw_ready = 1'b0;
    #3 rst = 1'b0;
    cmp_en = 1'b1;
    tick(2);
    check("reset ftw_valid", ftw_valid, 0);
    check("reset busy", busy, 1);
    check("reset freq_code", freq_code, 10);
    check("reset step_sel", step_sel, 0);
    check("reset ftw", ftw, 0);

    // 1: reset release loads the reset frequency and holds it until ready
    rst = 1'b1;
    tick(1);
    check("t1 valid after 1 cycle", ftw_valid, 0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("t1 valid held", ftw_valid, 1);
      check("t1 ftw held", ftw, 858990);
      tick(1);
    end
    ftw_ready = 1'b1;
    tick(1);
    check("t1 valid drop", ftw_valid, 0);
    check("t1 busy drop", busy, 0);

    // 2: one up press, then a glitch too short to qualify
    l0 = n_loads;
    press(1, 0, 0);
    check("t2 freq_code", freq_code, 11);
    check("t2 ftw", ftw, 944889);
    check("t2 load count", n_loads - l0, 1);
    key_up = 1'b0; tick(3); key_up = 1'b1; tick(12);
    check("t2 glitch code", freq_code, 11);
    check("t2 glitch loads", n_loads - l0, 1);

    // 3: step to 100, reach 350, saturate at 400
    press(0, 0, 1); press(0, 0, 1);
    check("t3 step_sel", step_sel, 2);
    press(0, 1, 0);
    check("t3 dn to zero", freq_code, 0);
    repeat (3) press(1, 0, 0);
    press(0, 0, 1); press(0, 0, 1);
    repeat (5) press(1, 0, 0);
    check("t3 code 350", freq_code, 350);
    press(0, 0, 1);
    press(1, 0, 0);
    check("t3 clamp code", freq_code, 400);
    check("t3 clamp ftw", ftw, 34359600);
    l0 = n_loads;
    press(1, 0, 0);
    check("t3 saturated no load", n_loads - l0, 0);
    check("t3 saturated code", freq_code, 400);

    // 4: floor at zero, then step+up in the same cycle
    repeat (4) press(0, 1, 0);
    press(0, 0, 1);
    repeat (5) press(1, 0, 0);
    press(0, 0, 1);
    check("t4 code 5", freq_code, 5);
    check("t4 step_sel 1", step_sel, 1);
    press(0, 1, 0);
    check("t4 floor code", freq_code, 0);
    check("t4 floor ftw", ftw, 0);
    l0 = n_loads;
    press(1, 0, 1);
    check("t4 step wins sel", step_sel, 2);
    check("t4 step wins code", freq_code, 0);
    check("t4 step wins loads", n_loads - l0, 0);

    // 5: press during a held load is dropped; reset aborts a load
    ftw_ready = 1'b0;
    press(1, 0, 0);
    press(1, 0, 0);
    check("t5 held valid", ftw_valid, 1);
    ftw_ready = 1'b1;
    tick(2);
    check("t5 code after load", freq_code, 100);
    check("t5 ftw after load", ftw, 8589900);
    ftw_ready = 1'b0;
    key_up = 1'b0; tick(6); key_up = 1'b1; tick(4);
    check("t5 second load valid", ftw_valid, 1);
    check("t5 second load code", freq_code, 200);
    rst = 1'b0;
    #1;
    check("t5 async valid clear", ftw_valid, 0);
    check("t5 async code", freq_code, 10);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("t5 reload valid", ftw_valid, 1);
    check("t5 reload ftw", ftw, 858990);
    ftw_ready = 1'b1;
    tick(3);

    // Randomized key and ready traffic, judged by the model every cycle
    for (int it = 0; it < 150; it++) begin
      key_up    = ($urandom_range(0, 2) != 0);
      key_dn    = ($urandom_range(0, 2) != 0);
      key_step  = ($urandom_range(0, 3) != 0);
      ftw_ready = ($urandom_range(0, 3) != 0);
      tick($urandom_range(1, 10));
    end
    key_up = 1'b1; key_dn = 1'b1; key_step = 1'b1; ftw_ready = 1'b1;
    tick(20);
    check("final idle valid", ftw_valid, 0);
    check("final idle busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
